reg_scoreboard: RTL

//  Producer-side tracker of in-flight register writes for the RV32 pipeline.
//  - Decode issues instructions into it; writeback retires them.
//  - Keeps a pending-write count per architectural register.
//  - Answers decode's rs1/rs2 busy queries and drives the issue handshake
//    (issue_ready), so decode holds while a source register is still pending.
//  - Complements the per-stage RAW/forward network: a register stays busy

---
 rtl/rv32_pkg.sv | 10 +
 rtl/sb_counter.sv | 47 ++++
 rtl/reg_scoreboard.sv | 101 ++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 register-file definitions used by the issue scoreboard.
package rv32_pkg;

   localparam int NUM_REGS = 32;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : rv32_pkg

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// A simultaneous increment and decrement cancel; clr discards both.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             nz,
   output logic             full
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: clear wins, otherwise a lone inc or dec moves the count by one.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign nz   = (cnt_q != '0);
   assign full = (cnt_q == CNT_MAX);

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writes between decode and writeback, answers
// the rs1/rs2 busy queries and drives the issue handshake. x0 is never tracked.
module reg_scoreboard
   import rv32_pkg::*;
#(
   parameter int CNT_W    = 2,
   parameter int NUM_REGS = rv32_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic                issue_wen,
   input  reg_idx_t            issue_rd,
   input  reg_idx_t            rs1_D,
   input  reg_idx_t            rs2_D,
   input  logic                use_rs2,
   input  logic                wb_valid,
   input  reg_idx_t            wb_rd,
   input  logic                flush,
   output logic                busy_rs1,
   output logic                busy_rs2,
   output logic                stall_D,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                err_underflow
);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_all;
   logic [NUM_REGS-1:0]            nz_vec;
   logic [NUM_REGS-1:0]            full_vec;
   logic [NUM_REGS-1:1]            inc_vec;
   logic [NUM_REGS-1:1]            dec_vec;

   logic sat;
   logic inc;
   logic wb_hit;
   logic wb_cnt_zero;
   logic dec;
   logic underflow;
   logic err_d;
   logic err_q;

   assign cnt_all[0]  = '0;
   assign nz_vec[0]   = 1'b0;
   assign full_vec[0] = 1'b0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc_vec[i]),
         .dec   (dec_vec[i]),
         .clr   (flush),
         .cnt   (cnt_all[i]),
         .nz    (nz_vec[i]),
         .full  (full_vec[i])
      );
   end

   // Queries look only at registered counts, so a same-cycle retire is seen next cycle.
   always_comb begin
      busy_rs1    = rst_n & nz_vec[rs1_D];
      busy_rs2    = rst_n & use_rs2 & nz_vec[rs2_D];
      busy_vec    = rst_n ? nz_vec : '0;
      sat         = issue_wen & (issue_rd != REG_ZERO) & full_vec[issue_rd];
      issue_ready = ~busy_rs1 & ~busy_rs2 & ~sat;
      stall_D     = issue_valid & ~issue_ready;
   end

   // Turn an accepted issue and a retiring writeback into one-hot counter strobes.
   always_comb begin
      inc         = issue_valid & issue_ready & issue_wen & (issue_rd != REG_ZERO);
      wb_hit      = wb_valid & (wb_rd != REG_ZERO);
      wb_cnt_zero = (cnt_all[wb_rd] == '0);
      dec         = wb_hit & ~wb_cnt_zero;
      underflow   = wb_hit & wb_cnt_zero;
      inc_vec     = '0;
      dec_vec     = '0;
      if (inc) begin
         inc_vec[issue_rd] = 1'b1;
      end
      if (dec) begin
         dec_vec[wb_rd] = 1'b1;
      end
      err_d = err_q | underflow;
   end

   // Sticky underflow flag; only reset clears it, flush leaves it alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_underflow = err_q;

endmodule : reg_scoreboard
